// File: rtl/ss_bram_capture_writer.sv
// Fabric-side port-A writer for the snapshot BRAM: arm, trigger, capture up to DEPTH samples, report done.
// Optional feature macro: SS_CAPTURE_TIMESTAMP_EN adds trig_ts, the free-running cycle count at trigger.
module ss_bram_capture_writer #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              arm,
    input  logic              trig,
    input  logic [ADDR_W-1:0] cfg_len,
    input  logic              din_valid,
    input  logic [DATA_W-1:0] din,
    output logic              bram_we,
    output logic              bram_en_a,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_wr_data,
    output logic              busy,
    output logic              done,
`ifdef SS_CAPTURE_TIMESTAMP_EN
    output logic [31:0]       trig_ts,
`endif
    output logic [ADDR_W:0]   wr_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_len;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic              w_arm_ok;
    logic              w_start;
    logic              w_accept;
    logic              w_last;

    // arm has priority over trig in ARMED so a re-arm never starts a capture
    assign w_arm_ok = arm && (r_state != S_CAPTURE);
    assign w_start  = (r_state == S_ARMED) && !arm && trig;
    assign w_accept = din_valid && (w_start || (r_state == S_CAPTURE));
    assign w_last   = w_accept && (r_ptr == r_len);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (arm) w_next = S_ARMED;
            end
            S_ARMED: begin
                if (arm)         w_next = S_ARMED;
                else if (trig)   w_next = w_last ? S_DONE : S_CAPTURE;
            end
            S_CAPTURE: begin
                if (w_last) w_next = S_DONE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == S_ARMED) || (r_state == S_CAPTURE);
        done = (r_state == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len   <= '0;
            r_ptr   <= '0;
            r_count <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
        end else begin
            r_we <= w_accept;
            if (w_arm_ok) begin
                r_len   <= cfg_len;
                r_ptr   <= '0;
                r_count <= '0;
            end else if (w_accept) begin
                // pointer parks on the last address so a full-depth run never wraps
                if (!w_last) r_ptr <= r_ptr + 1'b1;
                r_count <= r_count + 1'b1;
            end
            if (w_accept) begin
                r_addr <= r_ptr;
                r_data <= din;
            end
        end
    end

    assign bram_we      = r_we;
    assign bram_en_a    = r_we;
    assign bram_addr    = r_addr;
    assign bram_wr_data = r_data;
    assign wr_count     = r_count;

`ifdef SS_CAPTURE_TIMESTAMP_EN
    logic [31:0] r_cycle;
    logic [31:0] r_trig_ts;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cycle   <= '0;
            r_trig_ts <= '0;
        end else begin
            r_cycle <= r_cycle + 1'b1;
            if (w_start) r_trig_ts <= r_cycle;
        end
    end

    assign trig_ts = r_trig_ts;
`endif

endmodule

// File: tb/tb_ss_bram_capture_writer.sv
// Directed self-checking bench for ss_bram_capture_writer (trig_ts checks when SS_CAPTURE_TIMESTAMP_EN is set).
module tb_ss_bram_capture_writer;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              arm;
    logic              trig;
    logic [ADDR_W-1:0] cfg_len;
    logic              din_valid;
    logic [DATA_W-1:0] din;
    logic              bram_we;
    logic              bram_en_a;
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_wr_data;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   wr_count;
`ifdef SS_CAPTURE_TIMESTAMP_EN
    logic [31:0]       trig_ts;
`endif

    int checks = 0;
    int errors = 0;

    ss_bram_capture_writer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .arm          (arm),
        .trig         (trig),
        .cfg_len      (cfg_len),
        .din_valid    (din_valid),
        .din          (din),
        .bram_we      (bram_we),
        .bram_en_a    (bram_en_a),
        .bram_addr    (bram_addr),
        .bram_wr_data (bram_wr_data),
        .busy         (busy),
        .done         (done),
`ifdef SS_CAPTURE_TIMESTAMP_EN
        .trig_ts      (trig_ts),
`endif
        .wr_count     (wr_count)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs, then step to just after the next rising edge.
    task automatic applyStimulus(input logic a, input logic t, input logic [ADDR_W-1:0] len,
                                 input logic v, input logic [DATA_W-1:0] d);
        arm       = a;
        trig      = t;
        cfg_len   = len;
        din_valid = v;
        din       = d;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Port-A write strobe, address and data in one go.
    task automatic checkWrite(input string tag, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        checkOutput({tag, "_we"}, {63'd0, bram_we}, 64'd1);
        checkOutput({tag, "_en"}, {63'd0, bram_en_a}, 64'd1);
        checkOutput({tag, "_addr"}, 64'(bram_addr), 64'(a));
        checkOutput({tag, "_data"}, 64'(bram_wr_data), 64'(d));
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_we"}, {63'd0, bram_we}, 64'd0);
        checkOutput({tag, "_en"}, {63'd0, bram_en_a}, 64'd0);
        checkOutput({tag, "_addr"}, 64'(bram_addr), 64'd0);
        checkOutput({tag, "_data"}, 64'(bram_wr_data), 64'd0);
        checkOutput({tag, "_busy"}, {63'd0, busy}, 64'd0);
        checkOutput({tag, "_done"}, {63'd0, done}, 64'd0);
        checkOutput({tag, "_cnt"}, 64'(wr_count), 64'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        arm       = 1'b0;
        trig      = 1'b0;
        cfg_len   = '0;
        din_valid = 1'b0;
        din       = '0;
        #1;
        checkAllZero("reset");
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(negedge clk);

        // Test 1: four-word capture with continuous valid
        $display("[TB] test 1: cfg_len=3 continuous");
        applyStimulus(1, 0, 10'd3, 0, 32'h0);
        checkOutput("t1_armed_busy", {63'd0, busy}, 64'd1);
        checkOutput("t1_armed_we", {63'd0, bram_we}, 64'd0);
        checkOutput("t1_armed_cnt", 64'(wr_count), 64'd0);
        applyStimulus(0, 1, 10'd0, 1, 32'hA0);
        checkWrite("t1_w0", 10'd0, 32'hA0);
        checkOutput("t1_w0_busy", {63'd0, busy}, 64'd1);
        applyStimulus(0, 1, 10'd0, 1, 32'hA1);
        checkWrite("t1_w1", 10'd1, 32'hA1);
        applyStimulus(0, 0, 10'd0, 1, 32'hA2);
        checkWrite("t1_w2", 10'd2, 32'hA2);
        checkOutput("t1_w2_done", {63'd0, done}, 64'd0);
        applyStimulus(0, 0, 10'd0, 1, 32'hA3);
        checkWrite("t1_w3", 10'd3, 32'hA3);
        checkOutput("t1_done", {63'd0, done}, 64'd1);
        checkOutput("t1_busy", {63'd0, busy}, 64'd0);
        checkOutput("t1_cnt", 64'(wr_count), 64'd4);
        applyStimulus(0, 0, 10'd0, 1, 32'hA4);
        checkOutput("t1_after_we", {63'd0, bram_we}, 64'd0);
        checkOutput("t1_after_addr", 64'(bram_addr), 64'd3);
        checkOutput("t1_after_data", 64'(bram_wr_data), 64'hA3);
        checkOutput("t1_after_cnt", 64'(wr_count), 64'd4);

        // Test 2: full-depth capture
        $display("[TB] test 2: cfg_len=1023 full depth");
        applyStimulus(1, 0, 10'd1023, 0, 32'h0);
        checkOutput("t2_armed_done", {63'd0, done}, 64'd0);
        checkOutput("t2_armed_cnt", 64'(wr_count), 64'd0);
        for (int i = 0; i < 1024; i++) begin
            applyStimulus(0, (i == 0), 10'd0, 1, 32'h1000_0000 + i);
            checkOutput("t2_we", {63'd0, bram_we}, 64'd1);
            checkOutput("t2_addr", 64'(bram_addr), 64'(i));
            checkOutput("t2_data", 64'(bram_wr_data), 64'h1000_0000 + 64'(i));
            checkOutput("t2_done", {63'd0, done}, (i == 1023) ? 64'd1 : 64'd0);
        end
        checkOutput("t2_cnt", 64'(wr_count), 64'd1024);
        applyStimulus(0, 0, 10'd0, 1, 32'hDEAD);
        checkOutput("t2_after_we", {63'd0, bram_we}, 64'd0);
        checkOutput("t2_after_addr", 64'(bram_addr), 64'd1023);
        checkOutput("t2_after_cnt", 64'(wr_count), 64'd1024);

        // Test 3: valid toggling 1010..
        $display("[TB] test 3: cfg_len=7 toggling valid");
        applyStimulus(1, 0, 10'd7, 0, 32'h0);
        for (int k = 0; k < 16; k++) begin
            applyStimulus(0, (k == 0), 10'd0, (k % 2 == 0), 32'hB0 + k);
            checkOutput("t3_we", {63'd0, bram_we}, (k % 2 == 0) ? 64'd1 : 64'd0);
            if (k % 2 == 0) begin
                checkOutput("t3_addr", 64'(bram_addr), 64'(k / 2));
                checkOutput("t3_data", 64'(bram_wr_data), 64'hB0 + 64'(k));
            end
        end
        checkOutput("t3_done", {63'd0, done}, 64'd1);
        checkOutput("t3_cnt", 64'(wr_count), 64'd8);

        // Test 4: ignored trig in DONE, ignored arm in CAPTURE
        $display("[TB] test 4: ignored events");
        applyStimulus(0, 1, 10'd0, 1, 32'hC0);
        checkOutput("t4_donetrig_we", {63'd0, bram_we}, 64'd0);
        checkOutput("t4_donetrig_done", {63'd0, done}, 64'd1);
        checkOutput("t4_donetrig_cnt", 64'(wr_count), 64'd8);
        applyStimulus(1, 0, 10'd3, 0, 32'h0);
        applyStimulus(0, 1, 10'd0, 1, 32'hC1);
        checkWrite("t4_w0", 10'd0, 32'hC1);
        applyStimulus(1, 0, 10'd0, 1, 32'hC2);
        checkWrite("t4_w1", 10'd1, 32'hC2);
        checkOutput("t4_arm_busy", {63'd0, busy}, 64'd1);
        checkOutput("t4_arm_cnt", 64'(wr_count), 64'd2);
        applyStimulus(0, 0, 10'd0, 1, 32'hC3);
        applyStimulus(0, 0, 10'd0, 1, 32'hC4);
        checkWrite("t4_w3", 10'd3, 32'hC4);
        checkOutput("t4_done", {63'd0, done}, 64'd1);
        checkOutput("t4_cnt", 64'(wr_count), 64'd4);

        // Test 5: reset mid-capture, trig before arm, then re-arm
        $display("[TB] test 5: async reset mid-capture");
        applyStimulus(1, 0, 10'd15, 0, 32'h0);
        applyStimulus(0, 1, 10'd0, 1, 32'hD0);
        applyStimulus(0, 0, 10'd0, 1, 32'hD1);
        applyStimulus(0, 0, 10'd0, 1, 32'hD2);
        applyStimulus(0, 0, 10'd0, 1, 32'hD3);
        checkWrite("t5_w3", 10'd3, 32'hD3);
        din = 32'hD4;
        #2;
        rst_n = 1'b0;
        #1;
        checkAllZero("t5_rst");
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(0, 1, 10'd0, 1, 32'hE0);
        checkOutput("t5_pretrig_we", {63'd0, bram_we}, 64'd0);
        checkOutput("t5_pretrig_busy", {63'd0, busy}, 64'd0);
        applyStimulus(1, 0, 10'd1, 0, 32'h0);
        applyStimulus(0, 1, 10'd0, 1, 32'hE1);
        checkWrite("t5_re_w0", 10'd0, 32'hE1);
        applyStimulus(0, 1, 10'd0, 1, 32'hE2);
        checkWrite("t5_re_w1", 10'd1, 32'hE2);
        checkOutput("t5_re_done", {63'd0, done}, 64'd1);
        checkOutput("t5_re_cnt", 64'(wr_count), 64'd2);

`ifdef SS_CAPTURE_TIMESTAMP_EN
        // Test 6: trig_ts captures cycle counter value at trigger
        $display("[TB] test 6: trigger timestamp");
        applyStimulus(0, 0, 10'd0, 0, 32'h0);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_rst_ts", 64'(trig_ts), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1, 0, 10'd3, 0, 32'h0);
        for (int c = 1; c < 100; c++) applyStimulus(0, 0, 10'd3, 0, 32'h0);
        applyStimulus(0, 1, 10'd0, 0, 32'h0);
        checkOutput("t6_ts", 64'(trig_ts), 64'd100);
        for (int c = 0; c < 10; c++) applyStimulus(0, 1, 10'd0, (c < 4), 32'hF0 + c);
        checkOutput("t6_ts_hold", 64'(trig_ts), 64'd100);
        checkOutput("t6_done", {63'd0, done}, 64'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
